alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU, successor to the 32-bit 8-operation ALU. It adds a generic datapath width, a 4-bit opcode with signed and unsigned divide/remainder and unsigned compare, and status flags. All operations use a single start/done handshake. It sits between the register-operand stage and writeback, and holds its last result until the next accepted operation.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width in bits; any value ≥ 4.

Ports:
- `clk` in, 1 bit: clock; all state changes on the rising edge.
- `reset` in, 1 bit: synchronous, active-high reset.
- `start` in, 1 bit: request; accepted only on an edge where `done`=1.
- `A` in, WIDTH bits: operand A; sampled on the accepting edge.
- `B` in, WIDTH bits: operand B; sampled on the accepting edge.
- `ALUop` in, 4 bits: operation select; sampled on the accepting edge.
- `Result` out, WIDTH bits: registered result.
- `done` out, 1 bit: level. 1 = idle and `Result` valid; 0 = busy.
- `ovf` out, 1 bit: signed overflow of ADD/SUB.
- `dz` out, 1 bit: divide by zero on ops 0111–1010.
- `zero` out, 1 bit: `Result` == 0.

## Operation
- Opcodes, all registered:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
  - 0100 SLT (signed, result in bit 0), 1011 SLTU (unsigned).
  - 0101 ADD, 0110 SUB, mod 2^WIDTH.
  - 0111 MOD: unsigned remainder.
  - 1000 DIVU: unsigned quotient.
  - 1001 DIV: signed quotient, truncated toward zero.
  - 1010 REM: signed remainder; sign follows A.
  - 1100–1111: `Result`=0, all flags 0.
- State machine (IDLE, DIVIDE, FINISH):
  - IDLE, start=1, single-cycle op (0000–0110, 1011–1111): write `Result` and flags on that edge; stay in IDLE.
  - IDLE, start=1, divide op (0111–1010), B≠0: latch operand magnitudes and sign info, clear the counter, go to DIVIDE.
  - IDLE, start=1, divide op, B=0: single-cycle. Quotient ops give all-ones; remainder ops give A. `dz`=1.
  - DIVIDE: one restoring shift-subtract step per cycle. After WIDTH steps, go to FINISH.
  - FINISH: apply sign correction (negate the quotient if the signs differ; negate the remainder if A<0). Write `Result` and flags, go to IDLE.
- Signed MIN / −1 yields quotient = MIN and remainder = 0, with `ovf`=0 and no special path.
- `ovf` is valid for ADD/SUB only and is 0 for every other op. `zero` tracks the written `Result`.
- `start` while busy is ignored. Changes to `A`, `B` or `ALUop` while busy have no effect.

## Timing
- Reset values: `Result`=0, `done`=1, `ovf`=0, `dz`=0, `zero`=1. State = IDLE, counter = 0.
- Reset mid-divide takes priority: the next edge applies reset values and discards the operation. No stale result is written.
- Single-cycle ops: latency 1 edge. `Result` is visible after the accepting edge and `done` never drops.
- Divide ops with B≠0:
  - `done` falls after the accepting edge.
  - `done` rises, with `Result` valid, after edge WIDTH+1 counted from the accepting edge (33 cycles at WIDTH=32).
- Back-to-back: `start` held high on the edge where `done` is already 1 is accepted. An operation can be accepted on the first edge after `done` rises.
- Counter width is $clog2(WIDTH)+1 bits. The counter saturates at no point because it is cleared on every accept.

## Structure
- Package `alu_seq_pkg` holds:
  - the 4-bit opcode localparams (OP_AND … OP_SLTU);
  - the state enum (ST_IDLE, ST_DIVIDE, ST_FINISH).
- Sub-module `seq_divider` (parameter WIDTH):
  - unsigned restoring divider with start/busy/valid and quotient/remainder outputs;
  - `alu_seq` wraps it with magnitude conversion and sign fix-up.
- Single-cycle logic stays in `alu_seq`.

## Test plan
- **Unsigned MOD:** WIDTH=32, MOD 101 % 34. Expect `Result`=33, `done` low for exactly 32 cycles and high after edge 33. Then run 27 % 25 = 2 and 24 % 8 = 0 with `zero`=1.
- **Signed DIV/REM:** WIDTH=32, A=−7, B=2. DIV → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1). MIN / −1 → 0x80000000 with `ovf`=0.
- **Divide by zero:** DIVU 5 / 0 gives 0xFFFFFFFF and `dz`=1, with `done` never low. MOD 5 % 0 gives 5 and `dz`=1.
- **ADD/SUB overflow:** ADD 0x7FFFFFFF + 1 gives 0x80000000, `ovf`=1. SUB 2 − 4 gives 0xFFFFFFFE, `ovf`=0. SLT(−1, 1)=1; SLTU(−1, 1)=0.
- **Protocol and reset:**
  - Start a DIVU, then on cycle 5 pulse `start` with AND: ignored, and the DIVU result is correct.
  - Assert `reset` on cycle 10 of a divide: next edge gives `done`=1, `Result`=0, `zero`=1.
- **Narrow width:** WIDTH=8, DIVU 200 / 7 gives 28 with latency 9 edges. ADD 200 + 100 gives 44.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode constants and FSM state type for alu_seq
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MOD  = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_REM  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH:0]   trial, diff;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, valid_q, valid_d;

    // The load edge already retires the first quotient bit, so the busy
    // phase needs only WIDTH-1 further steps.
    assign last = busy_q && (cnt_q == CW'(WIDTH - 2));

    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem, src_quo[WIDTH-1]};
        diff    = trial - {1'b0, src_dvs};

        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = valid_q;

        if (start || busy_q) begin
            dvs_d = src_dvs;
            if (diff[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b1};
            end
        end

        if (start) begin
            cnt_d   = '0;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with signed/unsigned divide and status flags
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] Result,
    output logic             done,
    output logic             ovf,
    output logic             dz,
    output logic             zero
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d, dz_q, dz_d;
    logic [3:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;

    logic [WIDTH-1:0] sum, dif, a_mag, b_mag;
    logic             is_div, is_signed, div_start;
    logic             div_busy, div_valid, div_last;
    logic [WIDTH-1:0] div_quo, div_rem;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .valid     (div_valid),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        sum       = A + B;
        dif       = A - B;
        is_div    = ALUop inside {OP_MOD, OP_DIVU, OP_DIV, OP_REM};
        is_signed = (ALUop == OP_DIV) || (ALUop == OP_REM);
        a_mag     = (is_signed && A[WIDTH-1]) ? '0 - A : A;
        b_mag     = (is_signed && B[WIDTH-1]) ? '0 - B : B;

        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    dz_d  = 1'b0;
                    if (is_div && (B != '0)) begin
                        div_start = 1'b1;
                        op_d      = ALUop;
                        a_neg_d   = is_signed && A[WIDTH-1];
                        b_neg_d   = is_signed && B[WIDTH-1];
                        state_d   = ST_DIVIDE;
                    end else begin
                        result_d = '0;
                        case (ALUop)
                            OP_AND:  result_d = A & B;
                            OP_OR:   result_d = A | B;
                            OP_XOR:  result_d = A ^ B;
                            OP_NOR:  result_d = ~(A | B);
                            OP_SLT:  result_d[0] = $signed(A) < $signed(B);
                            OP_SLTU: result_d[0] = A < B;
                            OP_ADD: begin
                                result_d = sum;
                                ovf_d    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                            end
                            OP_SUB: begin
                                result_d = dif;
                                ovf_d    = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
                            end
                            // Only reached with B == 0 for the divide opcodes.
                            OP_MOD, OP_REM: begin
                                result_d = A;
                                dz_d     = 1'b1;
                            end
                            OP_DIVU, OP_DIV: begin
                                result_d = '1;
                                dz_d     = 1'b1;
                            end
                            default: result_d = '0;
                        endcase
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_last || !div_busy) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (div_valid) begin
                    case (op_q)
                        OP_DIVU: result_d = div_quo;
                        OP_DIV:  result_d = (a_neg_q ^ b_neg_q) ? '0 - div_quo : div_quo;
                        OP_REM:  result_d = a_neg_q ? '0 - div_rem : div_rem;
                        default: result_d = div_rem;
                    endcase
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            op_q     <= OP_AND;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end

    assign Result = result_q;
    assign done   = (state_q == ST_IDLE);
    assign ovf    = ovf_q;
    assign dz     = dz_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH 32 and 8
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, r32;
    logic [7:0]  a8 = '0, b8 = '0, r8;
    logic [3:0]  op32 = '0, op8 = '0;
    logic        done32, ovf32, dz32, zero32;
    logic        done8, ovf8, dz8, zero8;
    int          checks = 0;
    int          errors = 0;
    int          lat, lows;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .A(a32), .B(b32), .ALUop(op32),
        .Result(r32), .done(done32), .ovf(ovf32), .dz(dz32), .zero(zero32)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .ALUop(op8),
        .Result(r8), .done(done8), .ovf(ovf8), .dz(dz8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request and returns after the accepting edge.
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0; op32 = OP_SUB;
    endtask

    // Counts edges (accepting edge = 1) until done is seen high, bounded.
    task automatic wait32(input int from, output int l, output int low);
        l = from; low = 0;
        while (!done32 && l < 200) begin
            low++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int low);
        issue32(op, a, b);
        wait32(1, l, low);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_result", r32, 32'h0);
        check("rst_done", {31'b0, done32}, 32'h1);
        check("rst_ovf", {31'b0, ovf32}, 32'h0);
        check("rst_dz", {31'b0, dz32}, 32'h0);
        check("rst_zero", {31'b0, zero32}, 32'h1);

        run32(OP_MOD, 32'd101, 32'd34, lat, lows);
        check("mod101_res", r32, 32'd33);
        check("mod101_lat", lat, 33);
        check("mod101_lows", lows, 32);
        check("mod101_dz", {31'b0, dz32}, 32'h0);
        run32(OP_MOD, 32'd27, 32'd25, lat, lows);
        check("mod27_res", r32, 32'd2);
        check("mod27_lat", lat, 33);
        run32(OP_MOD, 32'd24, 32'd8, lat, lows);
        check("mod24_res", r32, 32'd0);
        check("mod24_zero", {31'b0, zero32}, 32'h1);

        run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, lows);
        check("div_m7_2", r32, 32'hFFFF_FFFD);
        run32(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, lows);
        check("rem_m7_2", r32, 32'hFFFF_FFFF);
        run32(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, lows);
        check("div_7_m2", r32, 32'hFFFF_FFFD);
        run32(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, lows);
        check("rem_7_m2", r32, 32'd1);
        run32(OP_DIVU, 32'hFFFF_FFF9, 32'd2, lat, lows);
        check("divu_big", r32, 32'h7FFF_FFFC);
        run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, lows);
        check("div_min_res", r32, 32'h8000_0000);
        check("div_min_ovf", {31'b0, ovf32}, 32'h0);
        run32(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, lows);
        check("rem_min_res", r32, 32'h0);
        check("rem_min_zero", {31'b0, zero32}, 32'h1);

        run32(OP_DIVU, 32'd5, 32'd0, lat, lows);
        check("divu_dz_res", r32, 32'hFFFF_FFFF);
        check("divu_dz_flag", {31'b0, dz32}, 32'h1);
        check("divu_dz_lows", lows, 0);
        run32(OP_MOD, 32'd5, 32'd0, lat, lows);
        check("mod_dz_res", r32, 32'd5);
        check("mod_dz_flag", {31'b0, dz32}, 32'h1);
        run32(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, lows);
        check("div_dz_res", r32, 32'hFFFF_FFFF);
        run32(OP_REM, 32'hFFFF_FFF9, 32'd0, lat, lows);
        check("rem_dz_res", r32, 32'hFFFF_FFF9);

        run32(OP_ADD, 32'h7FFF_FFFF, 32'd1, lat, lows);
        check("add_ovf_res", r32, 32'h8000_0000);
        check("add_ovf_flag", {31'b0, ovf32}, 32'h1);
        check("add_dz_clr", {31'b0, dz32}, 32'h0);
        check("add_lat", lat, 1);
        run32(OP_SUB, 32'd2, 32'd4, lat, lows);
        check("sub_res", r32, 32'hFFFF_FFFE);
        check("sub_ovf", {31'b0, ovf32}, 32'h0);
        run32(OP_SUB, 32'h8000_0000, 32'd1, lat, lows);
        check("sub_ovf_res", r32, 32'h7FFF_FFFF);
        check("sub_ovf_flag", {31'b0, ovf32}, 32'h1);
        run32(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat, lows);
        check("and_res", r32, 32'h00F0_1200);
        check("and_ovf", {31'b0, ovf32}, 32'h0);
        run32(OP_OR, 32'hF000_0001, 32'h0000_1000, lat, lows);
        check("or_res", r32, 32'hF000_1001);
        run32(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, lat, lows);
        check("xor_res", r32, 32'hF0F0_0F0F);
        run32(OP_NOR, 32'h0000_00FF, 32'h0000_FF00, lat, lows);
        check("nor_res", r32, 32'hFFFF_0000);
        run32(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, lows);
        check("slt_res", r32, 32'd1);
        run32(OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat, lows);
        check("sltu_res", r32, 32'd0);
        check("sltu_zero", {31'b0, zero32}, 32'h1);
        run32(OP_SLTU, 32'd1, 32'hFFFF_FFFF, lat, lows);
        check("sltu_res1", r32, 32'd1);
        run32(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, lows);
        check("op1101_res", r32, 32'd0);

        issue32(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start32 = 1'b1; op32 = OP_AND; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start32 = 1'b0;
        check("busy_ignored_done", {31'b0, done32}, 32'h0);
        wait32(5, lat, lows);
        check("busy_divu_res", r32, 32'd14);
        check("busy_divu_lat", lat, 33);

        issue32(OP_DIVU, 32'd1000, 32'd3);
        repeat (8) @(posedge clk);
        #1;
        check("mid_div_busy", {31'b0, done32}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_done", {31'b0, done32}, 32'h1);
        check("mid_rst_res", r32, 32'h0);
        check("mid_rst_zero", {31'b0, zero32}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_res", r32, 32'h0);

        @(negedge clk);
        start8 = 1'b1; op8 = OP_DIVU; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_divu_res", {24'b0, r8}, 32'd28);
        check("w8_divu_lat", lat, 9);
        @(negedge clk);
        start8 = 1'b1; op8 = OP_ADD; a8 = 8'd200; b8 = 8'd100;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("w8_add_res", {24'b0, r8}, 32'd44);
        check("w8_add_ovf", {31'b0, ovf8}, 32'h0);
        @(negedge clk);
        start8 = 1'b1; op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("w8_ovf_flag", {31'b0, ovf8}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
